harvard_core: RTL and testbench

Parametrised multi-cycle Harvard CPU core, the successor to the fixed 8-bit CPU. It has separate program and data memory ports and four general registers, and both widths are generic. It adds a ready/valid handshake on data memory (wait states), Z/C flags, conditional branches and a halt state. It sits at the top of the processor hierarchy: the program ROM and the data RAM (or its arbiter) attach directly to its ports.

---
 rtl/harvard_pkg.sv | 52 +++++
 rtl/harvard_alu.sv | 48 ++++
 rtl/harvard_core.sv | 172 +++++++++++++++++
 tb/tb_harvard_core.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/harvard_pkg.sv
// rtl/harvard_pkg.sv - shared opcodes, FSM states, field positions and reset constants for harvard_core
package harvard_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDI = 4'h1,
        OP_LD  = 4'h2,
        OP_ST  = 4'h3,
        OP_ADD = 4'h4,
        OP_SUB = 4'h5,
        OP_AND = 4'h6,
        OP_OR  = 4'h7,
        OP_XOR = 4'h8,
        OP_SHL = 4'h9,
        OP_SHR = 4'hA,
        OP_JMP = 4'hB,
        OP_JZ  = 4'hC,
        OP_JC  = 4'hD,
        OP_MOV = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    // Instruction word is {opcode[3:0], rd[1:0], rs[1:0], imm[DATA_W-1:0]}
    function automatic int instr_width(input int dw);
        return dw + 8;
    endfunction

    function automatic int field_op_lsb(input int dw);
        return dw + 4;
    endfunction

    function automatic int field_rd_lsb(input int dw);
        return dw + 2;
    endfunction

    function automatic int field_rs_lsb(input int dw);
        return dw;
    endfunction

    localparam state_e RESET_STATE = ST_FETCH;
    localparam logic   RESET_FLAG  = 1'b0;
    localparam logic   RESET_REQ   = 1'b0;

endpackage

// File: rtl/harvard_alu.sv
// rtl/harvard_alu.sv - combinational ALU for the register ops, producing result, zero and carry
module harvard_alu
    import harvard_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  opcode_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              z,
    output logic              c
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // The extra top bit is the carry for ADD and the borrow (b > a) for SUB
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Result and carry per opcode; non-ALU opcodes give zero and are ignored by the core
    always_comb begin
        result = '0;
        c      = 1'b0;
        case (op)
            OP_ADD:  {c, result} = sum;
            OP_SUB:  {c, result} = diff;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                c      = a[DATA_W-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                c      = a[0];
            end
            default: begin
                result = '0;
                c      = 1'b0;
            end
        endcase
        z = (result == '0);
    end

endmodule

// File: rtl/harvard_core.sv
// rtl/harvard_core.sv - multi-cycle Harvard CPU core with FSM, register file, PC and data handshake
module harvard_core
    import harvard_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PADDR_W = 8,
    parameter int DADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PADDR_W-1:0]  pm_addr,
    input  logic [DATA_W+7:0]   pm_data,
    output logic                dm_req,
    output logic                dm_we,
    output logic [DADDR_W-1:0]  dm_addr,
    output logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W-1:0]   dm_rdata,
    input  logic                dm_ready,
    output logic                halted
);

    localparam int IW     = instr_width(DATA_W);
    localparam int OP_LSB = field_op_lsb(DATA_W);
    localparam int RD_LSB = field_rd_lsb(DATA_W);
    localparam int RS_LSB = field_rs_lsb(DATA_W);

    state_e              state_q,    state_d;
    logic [PADDR_W-1:0]  pc_q,       pc_d;
    logic [IW-1:0]       ir_q,       ir_d;
    logic [DATA_W-1:0]   regs_q [4];
    logic [DATA_W-1:0]   regs_d [4];
    logic                z_q,        z_d;
    logic                c_q,        c_d;
    logic [PADDR_W-1:0]  pm_addr_q,  pm_addr_d;
    logic                dm_req_q,   dm_req_d;
    logic                dm_we_q,    dm_we_d;
    logic [DADDR_W-1:0]  dm_addr_q,  dm_addr_d;
    logic [DATA_W-1:0]   dm_wdata_q, dm_wdata_d;

    opcode_e             op;
    logic [1:0]          rd;
    logic [1:0]          rs;
    logic [DATA_W-1:0]   imm;
    logic [PADDR_W-1:0]  target;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_z;
    logic                alu_c;

    assign op     = opcode_e'(ir_q[OP_LSB +: 4]);
    assign rd     = ir_q[RD_LSB +: 2];
    assign rs     = ir_q[RS_LSB +: 2];
    assign imm    = ir_q[DATA_W-1:0];
    assign target = imm[PADDR_W-1:0];

    harvard_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (op),
        .a      (regs_q[rd]),
        .b      (regs_q[rs]),
        .result (alu_result),
        .z      (alu_z),
        .c      (alu_c)
    );

    // Next-state, register-file, PC and data-port decisions for the current FSM state
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        regs_d     = regs_q;
        z_d        = z_q;
        c_d        = c_q;
        pm_addr_d  = pm_addr_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;

        case (state_q)
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d    = pm_data;
                pc_d    = pc_q + PADDR_W'(1);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (op)
                    OP_LDI: regs_d[rd] = imm;
                    OP_LD, OP_ST: begin
                        dm_req_d   = 1'b1;
                        dm_we_d    = (op == OP_ST);
                        dm_addr_d  = imm[DADDR_W-1:0];
                        dm_wdata_d = regs_q[rs];
                        state_d    = ST_MEM;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                        regs_d[rd] = alu_result;
                        z_d        = alu_z;
                        c_d        = alu_c;
                    end
                    OP_JMP: pc_d = target;
                    OP_JZ:  if (z_q) pc_d = target;
                    OP_JC:  if (c_q) pc_d = target;
                    OP_MOV: regs_d[rd] = regs_q[rs];
                    OP_HLT: state_d = ST_HALT;
                    default: begin
                    end
                endcase
            end
            ST_MEM: begin
                if (dm_req_q && dm_ready) begin
                    if (!dm_we_q) begin
                        regs_d[rd] = dm_rdata;
                    end
                    dm_req_d = 1'b0;
                    state_d  = ST_FETCH;
                end
            end
            ST_HALT: begin
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // The fetch address only moves when a fetch is about to happen, so it freezes in HALT
        if (state_d == ST_FETCH) begin
            pm_addr_d = pc_d;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RESET_STATE;
            pc_q       <= '0;
            ir_q       <= '0;
            regs_q     <= '{default: '0};
            z_q        <= RESET_FLAG;
            c_q        <= RESET_FLAG;
            pm_addr_q  <= '0;
            dm_req_q   <= RESET_REQ;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            regs_q     <= regs_d;
            z_q        <= z_d;
            c_q        <= c_d;
            pm_addr_q  <= pm_addr_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
        end
    end

    assign pm_addr  = pm_addr_q;
    assign dm_req   = dm_req_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = dm_addr_q;
    assign dm_wdata = dm_wdata_q;
    assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_harvard_core.sv
// tb/tb_harvard_core.sv - randomized and directed self-checking bench for harvard_core
module tb_harvard_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  pm_addr;
    logic [15:0] pm_data;
    logic        dm_req, dm_we, halted;
    logic [7:0]  dm_addr, dm_wdata, dm_rdata;
    logic        dm_ready = 1'b0;

    logic [9:0]  pm_addr16;
    logic [23:0] pm_data16;
    logic        dm_req16, dm_we16, halted16;
    logic [7:0]  dm_addr16;
    logic [15:0] dm_wdata16;
    logic [15:0] dm_rdata16 = 16'h0;
    logic        dm_ready16 = 1'b1;

    logic [15:0] rom   [256];
    logic [7:0]  ram   [256];
    logic [23:0] rom16 [1024];

    always @(posedge clk) pm_data   <= rom[pm_addr];
    always @(posedge clk) pm_data16 <= rom16[pm_addr16];
    assign dm_rdata = ram[dm_addr];

    harvard_core u_dut (
        .clk(clk), .rst(rst), .pm_addr(pm_addr), .pm_data(pm_data),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready), .halted(halted)
    );

    harvard_core #(.DATA_W(16), .PADDR_W(10), .DADDR_W(8)) u_dut16 (
        .clk(clk), .rst(rst), .pm_addr(pm_addr16), .pm_data(pm_data16),
        .dm_req(dm_req16), .dm_we(dm_we16), .dm_addr(dm_addr16), .dm_wdata(dm_wdata16),
        .dm_rdata(dm_rdata16), .dm_ready(dm_ready16), .halted(halted16)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] i8(input int op, input int rd, input int rs, input int imm);
        return {4'(op), 2'(rd), 2'(rs), 8'(imm)};
    endfunction

    function automatic logic [23:0] i16(input int op, input int rd, input int rs, input int imm);
        return {4'(op), 2'(rd), 2'(rs), 16'(imm)};
    endfunction

    // Bench-side observation state
    int          ready_mode;
    int          req_len, waits, unstable, len_bad;
    logic [7:0]  lat_addr;
    logic        lat_we;
    logic [16:0] obs_tr [$];
    logic [7:0]  obs_pc [$];
    logic [7:0]  last_pm;
    logic [9:0]  obs16  [$];
    logic [9:0]  last16;
    logic [23:0] wr16;
    logic        got16;

    // Expected results from the instruction-level model
    logic [16:0] exp_tr [$];
    logic [7:0]  exp_pc [$];
    int          exp_cycles;
    int          exp_halt;

    // One clock: at the falling edge, observe outputs, pick dm_ready for the next rising edge
    task automatic step();
        @(negedge clk);
        if (dm_req) begin
            if (req_len == 0) begin
                lat_addr = dm_addr;
                lat_we   = dm_we;
            end else if (dm_addr !== lat_addr || dm_we !== lat_we) begin
                unstable++;
            end
        end
        case (ready_mode)
            0:       dm_ready = 1'b1;
            1:       dm_ready = 1'($urandom_range(0, 1));
            2:       dm_ready = (req_len >= 3);
            default: dm_ready = 1'b0;
        endcase
        if (dm_req) begin
            req_len++;
            if (dm_ready) begin
                obs_tr.push_back({dm_we, dm_addr, dm_we ? dm_wdata : 8'h00});
                if (dm_we) ram[dm_addr] = dm_wdata;
                if (ready_mode == 2 && req_len != 4) len_bad++;
                req_len = 0;
            end else begin
                waits++;
            end
        end
        if (pm_addr !== last_pm) begin
            obs_pc.push_back(pm_addr);
            last_pm = pm_addr;
        end
        if (pm_addr16 !== last16) begin
            obs16.push_back(pm_addr16);
            last16 = pm_addr16;
        end
        if (dm_req16 && dm_we16 && !got16) begin
            wr16  = {dm_addr16, dm_wdata16};
            got16 = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Instruction-set model: runs the 8-bit program from pc 0 until HLT
    task automatic model();
        int r [4];
        int pc, npc, z, c, s, op, rd, rs, imm, nsteps;
        bit done;
        logic [15:0] w;
        logic [7:0]  mram [256];
        for (int i = 0; i < 256; i++) mram[i] = ram[i];
        for (int i = 0; i < 4; i++) r[i] = 0;
        exp_tr.delete();
        exp_pc.delete();
        exp_cycles = 0;
        exp_halt   = 0;
        pc = 0; z = 0; c = 0; nsteps = 0; done = 1'b0;
        while (!done && nsteps < 1000) begin
            nsteps++;
            if (exp_pc.size() == 0 || exp_pc[$] != 8'(pc)) exp_pc.push_back(8'(pc));
            w   = rom[pc];
            op  = int'(w[15:12]);
            rd  = int'(w[11:10]);
            rs  = int'(w[9:8]);
            imm = int'(w[7:0]);
            npc = (pc + 1) % 256;
            exp_cycles += 3;
            case (op)
                1:  r[rd] = imm;
                2: begin
                    r[rd] = int'(mram[imm]);
                    exp_tr.push_back({1'b0, 8'(imm), 8'h00});
                    exp_cycles += 1;
                end
                3: begin
                    mram[imm] = 8'(r[rs]);
                    exp_tr.push_back({1'b1, 8'(imm), 8'(r[rs])});
                    exp_cycles += 1;
                end
                4: begin
                    s = r[rd] + r[rs];
                    c = (s > 255) ? 1 : 0;
                    r[rd] = s % 256;
                end
                5: begin
                    c = (r[rs] > r[rd]) ? 1 : 0;
                    r[rd] = (r[rd] - r[rs] + 256) % 256;
                end
                6:  begin r[rd] = r[rd] & r[rs]; c = 0; end
                7:  begin r[rd] = r[rd] | r[rs]; c = 0; end
                8:  begin r[rd] = r[rd] ^ r[rs]; c = 0; end
                9:  begin c = r[rd] / 128; r[rd] = (r[rd] * 2) % 256; end
                10: begin c = r[rd] % 2;   r[rd] = r[rd] / 2; end
                11: npc = imm;
                12: if (z != 0) npc = imm;
                13: if (c != 0) npc = imm;
                14: r[rd] = r[rs];
                15: begin exp_halt = pc; done = 1'b1; end
                default: begin end
            endcase
            if (op >= 4 && op <= 10) z = (r[rd] == 0) ? 1 : 0;
            pc = npc;
        end
    endtask

    // Run the loaded program on the DUT (reset already released) and compare against the model
    task automatic run_body(input string tag);
        int n;
        int ne;
        obs_tr.delete();
        obs_pc.delete();
        obs_pc.push_back(pm_addr);
        last_pm  = pm_addr;
        waits    = 0;
        unstable = 0;
        len_bad  = 0;
        req_len  = 0;
        model();
        n = 0;
        while (n < 3000 && !halted) begin
            step();
            n++;
        end
        chk({tag, " halted"}, 32'(halted), 32'd1);
        chk({tag, " cycles"}, 32'(n), 32'(exp_cycles + waits));
        chk({tag, " halt pc"}, 32'(pm_addr), 32'(exp_halt));
        chk({tag, " n access"}, 32'(obs_tr.size()), 32'(exp_tr.size()));
        ne = (obs_tr.size() < exp_tr.size()) ? obs_tr.size() : exp_tr.size();
        for (int i = 0; i < ne; i++) chk($sformatf("%s access%0d", tag, i), 32'(obs_tr[i]), 32'(exp_tr[i]));
        chk({tag, " n fetch"}, 32'(obs_pc.size()), 32'(exp_pc.size()));
        ne = (obs_pc.size() < exp_pc.size()) ? obs_pc.size() : exp_pc.size();
        for (int i = 0; i < ne; i++) chk($sformatf("%s fetch%0d", tag, i), 32'(obs_pc[i]), 32'(exp_pc[i]));
        chk({tag, " dm stable"}, 32'(unstable), 32'd0);
        chk({tag, " wait len"}, 32'(len_bad), 32'd0);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = i8(15, 0, 0, 0);
    endtask

    int          exp16 [9];
    int          cnt, bad, k;
    bit          found;
    logic [3:0]  rop;
    logic [7:0]  rimm;

    initial begin
        exp16 = '{0, 1, 2, 3, 5, 7, 8, 1023, 0};
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 1024; i++) rom16[i] = i16(15, 0, 0, 0);
        rom16[0]    = i16(1, 0, 0, 16'hFFFF);
        rom16[1]    = i16(1, 1, 0, 16'h0001);
        rom16[2]    = i16(4, 0, 1, 0);
        rom16[3]    = i16(12, 0, 0, 5);
        rom16[5]    = i16(13, 0, 0, 7);
        rom16[7]    = i16(3, 0, 0, 16'h0012);
        rom16[8]    = i16(11, 0, 0, 16'h03FF);
        rom16[1023] = i16(0, 0, 0, 0);

        // Reset state and a first small program
        clear_rom();
        rom[0] = i8(1, 1, 0, 8'h5A);
        rom[1] = i8(3, 0, 1, 8'h07);
        ready_mode = 0;
        got16 = 1'b0;
        do_reset();
        chk("reset pm_addr", 32'(pm_addr), 32'd0);
        chk("reset dm_req", 32'(dm_req), 32'd0);
        chk("reset halted", 32'(halted), 32'd0);
        obs16.delete();
        obs16.push_back(pm_addr16);
        last16 = pm_addr16;
        run_body("boot");

        // Wide build runs alongside; give it time to reach the wrap
        repeat (40) step();
        chk("w16 n fetch ok", 32'(obs16.size() >= 9), 32'd1);
        for (int i = 0; i < 9; i++)
            chk($sformatf("w16 fetch%0d", i), 32'(i < obs16.size() ? obs16[i] : 10'h155), 32'(exp16[i]));
        chk("w16 st seen", 32'(got16), 32'd1);
        chk("w16 st addr/data", 32'(wr16), {8'h0, 8'h12, 16'h0000});

        // Carry out of ADD drives a taken JC
        clear_rom();
        rom[0] = i8(1, 0, 0, 8'hF0);
        rom[1] = i8(1, 1, 0, 8'h20);
        rom[2] = i8(4, 0, 1, 0);
        rom[3] = i8(13, 0, 0, 8'h08);
        rom[8] = i8(3, 0, 0, 8'h10);
        do_reset();
        run_body("carry");
        chk("carry st", 32'(obs_tr.size() > 0 ? obs_tr[0] : 17'h0), {15'h0, 1'b1, 8'h10, 8'h10});
        cnt = 0;
        foreach (obs_pc[i]) if (obs_pc[i] == 8'h04) cnt++;
        chk("carry no fetch 04", 32'(cnt), 32'd0);

        // LD with three wait states, then store the loaded register
        clear_rom();
        ram[8'h33] = 8'hA5;
        rom[0] = i8(1, 2, 0, 8'h11);
        rom[1] = i8(2, 2, 0, 8'h33);
        rom[2] = i8(3, 0, 2, 8'h34);
        ready_mode = 2;
        do_reset();
        run_body("ldwait");
        chk("ldwait waits", 32'(waits), 32'd6);
        chk("ldwait ld", 32'(obs_tr.size() > 0 ? obs_tr[0] : 17'h1FFFF), {15'h0, 1'b0, 8'h33, 8'h00});
        chk("ldwait st", 32'(obs_tr.size() > 1 ? obs_tr[1] : 17'h0), {15'h0, 1'b1, 8'h34, 8'hA5});
        ready_mode = 0;

        // Zero flag from SUB r3,r3 and PC wrap from FF to 00
        clear_rom();
        rom[0]     = i8(12, 0, 0, 8'h08);
        rom[1]     = i8(1, 3, 0, 8'h05);
        rom[2]     = i8(5, 3, 3, 0);
        rom[3]     = i8(12, 0, 0, 8'hFF);
        rom[8'hFF] = i8(0, 0, 0, 0);
        do_reset();
        run_body("wrap");
        found = 1'b0;
        for (int i = 0; i + 1 < obs_pc.size(); i++)
            if (obs_pc[i] == 8'hFF && obs_pc[i+1] == 8'h00) found = 1'b1;
        chk("wrap ff then 00", 32'(found), 32'd1);

        // HALT holds: pm_addr frozen, no data requests
        clear_rom();
        rom[0] = i8(0, 0, 0, 0);
        rom[1] = i8(0, 0, 0, 0);
        do_reset();
        run_body("halt");
        bad = 0;
        repeat (20) begin
            step();
            if (pm_addr !== 8'h02 || dm_req !== 1'b0 || halted !== 1'b1) bad++;
        end
        chk("halt hold", 32'(bad), 32'd0);

        // Reset while stalled in MEM aborts the access and refetches from 0
        clear_rom();
        rom[0] = i8(1, 0, 0, 8'h77);
        rom[1] = i8(3, 0, 0, 8'h20);
        ram[8'h20] = 8'h00;
        do_reset();
        ready_mode = 3;
        k = 0;
        while (!dm_req && k < 20) begin
            step();
            k++;
        end
        chk("abort in MEM", 32'(dm_req), 32'd1);
        step();
        step();
        rst = 1'b1;
        step();
        chk("abort dm_req", 32'(dm_req), 32'd0);
        chk("abort pm_addr", 32'(pm_addr), 32'd0);
        chk("abort no write", 32'(ram[8'h20]), 32'd0);
        step();
        rst = 1'b0;
        ready_mode = 0;
        run_body("abort rerun");

        // Random programs: forward-only branches, stores of all registers before HLT
        for (int t = 0; t < 6; t++) begin
            clear_rom();
            for (int p = 0; p < 20; p++) begin
                rop  = 4'($urandom_range(0, 14));
                rimm = 8'($urandom);
                if (rop >= 4'hB && rop <= 4'hD) rimm = 8'($urandom_range(p + 1, 20));
                if (rop == 4'h2 || rop == 4'h3) rimm = 8'($urandom_range(8'h40, 8'h4F));
                rom[p] = {rop, 2'($urandom), 2'($urandom), rimm};
            end
            for (int q = 0; q < 4; q++) rom[20+q] = i8(3, 0, q, 8'h60 + q);
            ready_mode = t % 3;
            do_reset();
            run_body($sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
